usrmaxpool: RTL and testbench
=============================

Name: usrmaxpool

Overview:
- Streaming max-pool reducer for the non-linear-ops datapath.
- Consumes a stream of WIDTH-bit elements and emits the maximum, plus its index, of each consecutive non-overlapping window of POOL elements.
- Running-max selection is done by the team's 2:1 mux (usrmux). This block generates that mux's select and operands and registers its output, so it sits directly around/upstream of the mux stage.
- Used after activations for pooling layers.

Parameters:
- WIDTH, 64, element and result bit width.
- POOL, 4, window length in elements; legal range 2..256.
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare.
- IDX_W, $clog2(POOL), width of the count and index (derived; not to be overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input element valid.
- in_ready  output  1  block can accept an element this cycle.
- in_data  input  WIDTH  input element.
- out_valid  output  1  pooled result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  window maximum.
- out_idx  output  IDX_W  position (0..POOL-1) of the maximum within its window.

Behaviour:
- Reset: asynchronous, active-low, one clock; polarity and synchronicity fixed.
  - While rst_n=0: cnt=0, max_r=0, idx_r=0, out_valid=0, out_data=0, out_idx=0.
  - in_ready is combinational and therefore 1 during reset.
- Accept: an element is taken when in_valid && in_ready on a rising edge.
- State: cnt in 0..POOL-1 (position of the next element), max_r, idx_r.
- Compare and select:
  - sel = (cnt==0) || (in_data > max_r), using a signed or unsigned compare per SIGNED.
  - The usrmux instance gets usrmux_sel=sel, i1=in_data, i2=max_r; its output is next max_r.
  - idx_r is loaded with cnt when sel=1.
  - Ties (in_data == max_r) keep the earlier element: the lowest index wins.
- Window completion: when the accepted element has cnt==POOL-1:
  - out_data <= mux output, out_idx <= (sel ? cnt : idx_r), out_valid <= 1.
  - cnt wraps to 0.
  - Latency: result is visible in the cycle after the last element is accepted.
- Non-final accept: cnt <= cnt+1; the output register is untouched.
- Output handshake:
  - out_valid && out_ready clears out_valid, unless the same cycle completes a new window, in which case the output is reloaded and out_valid stays 1.
  - out_data and out_idx are stable while out_valid && !out_ready.
- Backpressure: in_ready = !(cnt==POOL-1 && out_valid && !out_ready).
  - Non-final elements are accepted even while a result is stalled.
  - Only the final element of the next window waits.
- Throughput: 1 element/cycle sustained, with no bubbles when out_ready=1; one result every POOL cycles.
- Simultaneous events: output pop and final-element accept in the same cycle is legal; the new result replaces the old with no gap.
- in_valid=0 holds all state.
- Reset mid-window discards the partial window and any pending result; the next accepted element is index 0.
- No arithmetic beyond compare; no width growth.

Decomposition:
- Shared package (usr_nl_pkg):
  - Signedness enum or constants USR_CMP_SIGNED / USR_CMP_UNSIGNED.
  - Default element width constant USR_WIDTH=64.
- One sub-module: usrmux, instantiated once for the running-max select.
  - The compare is inline, selected with a generate on SIGNED.
- Counter, state and output register stay in usrmaxpool.

Test Plan (bench uses WIDTH=8, POOL=4 unless noted):
- SIGNED=1, stream 3,7,-2,5, out_ready=1 -> one cycle after the 4th accept: out_data=7, out_idx=1, out_valid pulses for 1 cycle.
- Ties: stream 5,5,1,5 -> out_data=5, out_idx=0. All-negative stream -8,-3,-100,-3 -> out_data=-3, out_idx=1.
- SIGNED=0, stream 0xFE,0x01,0x7F,0x80 -> out_data=0xFE, out_idx=0. The same stream with SIGNED=1 -> out_data=0x7F, out_idx=2.
- Backpressure:
  - Setup: out_ready=0 after the first result; second window 1,2,3,9 driven back-to-back.
  - First three elements accepted; in_ready=0 at cnt=3.
  - Result 1 is held stable.
  - Raise out_ready -> 9 is accepted on the pop cycle; next cycle out_data=9, out_idx=3, out_valid stays 1.
- Reset mid-window:
  - Accept 10,20; assert rst_n=0 asynchronously between edges -> out_valid=0 and cnt=0 immediately.
  - Then stream 1,2,3,4 -> out_data=4, out_idx=3, with no contribution from 20.
- Continuous stream of 64 random elements, with in_valid and out_ready both held high -> 16 results, one every 4 cycles, each matching a scoreboard max/argmax model with lowest-index tie-break.

Source files
------------

// File: rtl/usr_nl_pkg.sv
// rtl/usr_nl_pkg.sv - shared constants for the non-linear-ops datapath
package usr_nl_pkg;

    localparam int USR_WIDTH = 64;

    localparam int USR_CMP_UNSIGNED = 0;
    localparam int USR_CMP_SIGNED   = 1;

endpackage

// File: rtl/usrmux.sv
// rtl/usrmux.sv - 2:1 operand mux, sel=1 picks i1
module usrmux
    import usr_nl_pkg::*;
#(
    parameter int WIDTH = USR_WIDTH
) (
    input  logic             usrmux_sel,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    output logic [WIDTH-1:0] o
);

    // Pure combinational select; no state in this stage.
    assign o = usrmux_sel ? i1 : i2;

endmodule

// File: rtl/usrmaxpool.sv
// rtl/usrmaxpool.sv - streaming max/argmax over non-overlapping windows of POOL elements
module usrmaxpool
    import usr_nl_pkg::*;
#(
    parameter int WIDTH  = USR_WIDTH,
    parameter int POOL   = 4,
    parameter int SIGNED = USR_CMP_SIGNED,
    parameter int IDX_W  = $clog2(POOL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(POOL - 1);

    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;

    logic             gt;
    logic             sel;
    logic             last;
    logic             accept;
    logic [WIDTH-1:0] mux_o;

    // Strictly-greater compare so ties keep the earlier (lower index) element.
    generate
        if (SIGNED != USR_CMP_UNSIGNED) begin : g_cmp_signed
            assign gt = $signed(in_data) > $signed(max_q);
        end else begin : g_cmp_unsigned
            assign gt = in_data > max_q;
        end
    endgenerate

    assign sel    = (cnt_q == '0) || gt;
    assign last   = (cnt_q == LAST);
    // Only the window-closing element has to wait for a stalled result.
    assign in_ready = !(last && out_valid_q && !out_ready);
    assign accept = in_valid && in_ready;

    usrmux #(
        .WIDTH (WIDTH)
    ) u_max_mux (
        .usrmux_sel (sel),
        .i1         (in_data),
        .i2         (max_q),
        .o          (mux_o)
    );

    // Next-state: running max update, window completion and output pop.
    always_comb begin
        cnt_d       = cnt_q;
        max_d       = max_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            max_d = mux_o;
            if (sel) begin
                idx_d = cnt_q;
            end
            if (last) begin
                cnt_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = mux_o;
                out_idx_d   = sel ? cnt_q : idx_q;
            end else begin
                cnt_d = cnt_q + IDX_W'(1);
            end
        end
    end

    // State and output registers; reset drops any partial window and pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_usrmaxpool.sv
// tb/tb_usrmaxpool.sv - scoreboard bench for usrmaxpool, signed and unsigned instances
module tb_usrmaxpool;

    localparam int W  = 8;
    localparam int P  = 4;
    localparam int IW = 2;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data   = '0;

    logic          in_ready_s, in_ready_u;
    logic          out_valid_s, out_valid_u;
    logic [W-1:0]  out_data_s, out_data_u;
    logic [IW-1:0] out_idx_s, out_idx_u;

    typedef struct {
        logic [W-1:0]  data;
        logic [IW-1:0] idx;
    } res_t;

    res_t         exp_s[$];
    res_t         exp_u[$];
    logic [W-1:0] win[$];

    int total     = 0;
    int passed    = 0;
    int results_s = 0;
    int results_u = 0;

    always #5 clk = ~clk;

    usrmaxpool #(.WIDTH(W), .POOL(P), .SIGNED(1)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_data   (in_data),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (out_data_s),
        .out_idx   (out_idx_s)
    );

    usrmaxpool #(.WIDTH(W), .POOL(P), .SIGNED(0)) dut_u (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_u),
        .in_data   (in_data),
        .out_valid (out_valid_u),
        .out_ready (out_ready),
        .out_data  (out_data_u),
        .out_idx   (out_idx_u)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: first occurrence of the maximum of a complete window.
    function automatic res_t pool_ref(input logic [W-1:0] w[$], input bit sgn);
        res_t r;
        r.data = w[0];
        r.idx  = '0;
        for (int i = 1; i < P; i++) begin
            bit better;
            better = sgn ? ($signed(w[i]) > $signed(r.data)) : (w[i] > r.data);
            if (better) begin
                r.data = w[i];
                r.idx  = IW'(i);
            end
        end
        return r;
    endfunction

    // Drive one element from a negedge; record it in the model when the handshake will fire.
    task automatic send(input logic [W-1:0] d, output int stalls);
        bit done;
        done   = 0;
        stalls = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!done) begin
            #1;
            if (in_ready_s && in_ready_u) begin
                win.push_back(d);
                if (win.size() == P) begin
                    exp_s.push_back(pool_ref(win, 1'b1));
                    exp_u.push_back(pool_ref(win, 1'b0));
                    win.delete();
                end
                done = 1;
            end else begin
                stalls++;
                if (stalls > 50) begin
                    total++;
                    $display("FAIL send_timeout: in_ready low for %0d cycles, expected 1", stalls);
                    done = 1;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic send1(input logic [W-1:0] d);
        int s;
        send(d, s);
    endtask

    // Monitor: compare every presented result against the head of its queue; pop on handshake.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (out_valid_s) begin
                if (exp_s.size() == 0) begin
                    total++;
                    $display("FAIL mon_s_unexpected: out_valid=1 data=%0d, expected no result", out_data_s);
                end else begin
                    check("mon_s_data", out_data_s, exp_s[0].data);
                    check("mon_s_idx", out_idx_s, exp_s[0].idx);
                    if (out_ready) begin
                        void'(exp_s.pop_front());
                        results_s++;
                    end
                end
            end
            if (out_valid_u) begin
                if (exp_u.size() == 0) begin
                    total++;
                    $display("FAIL mon_u_unexpected: out_valid=1 data=%0d, expected no result", out_data_u);
                end else begin
                    check("mon_u_data", out_data_u, exp_u[0].data);
                    check("mon_u_idx", out_idx_u, exp_u[0].idx);
                    if (out_ready) begin
                        void'(exp_u.pop_front());
                        results_u++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    logic [W-1:0]  dir_tab  [4][4];
    logic [W-1:0]  dir_sdat [4];
    logic [IW-1:0] dir_sidx [4];

    initial begin
        int stalls;
        int bubbles;
        int base;

        dir_tab[0] = '{8'd3,   8'd7,   8'hFE, 8'd5};
        dir_tab[1] = '{8'd5,   8'd5,   8'd1,  8'd5};
        dir_tab[2] = '{8'hF8,  8'hFD,  8'h9C, 8'hFD};
        dir_tab[3] = '{8'hFE,  8'h01,  8'h7F, 8'h80};
        dir_sdat   = '{8'd7,   8'd5,   8'hFD, 8'h7F};
        dir_sidx   = '{2'd1,   2'd0,   2'd1,  2'd2};

        // Reset state.
        #3;
        check("rst_out_valid", out_valid_s, 0);
        check("rst_out_data", out_data_s, 0);
        check("rst_out_idx", out_idx_s, 0);
        check("rst_in_ready", in_ready_s, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // Directed windows with explicit expected signed results.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < P; j++) send1(dir_tab[k][j]);
            in_valid = 1'b0;
            #2;
            check("dir_valid", out_valid_s, 1);
            check("dir_data_s", out_data_s, dir_sdat[k]);
            check("dir_idx_s", out_idx_s, dir_sidx[k]);
            if (k == 3) begin
                check("dir_data_u", out_data_u, 8'hFE);
                check("dir_idx_u", out_idx_u, 0);
            end
            @(negedge clk);
            #2;
            check("dir_pulse", out_valid_s, 0);
            @(negedge clk);
        end

        // Backpressure: stall result 1, push window 2 up to its final element.
        out_ready = 1'b0;
        send1(8'd11); send1(8'd44); send1(8'd22); send1(8'd33);
        send1(8'd1);  send1(8'd2);  send1(8'd3);
        in_valid = 1'b1;
        in_data  = 8'd9;
        #1;
        check("bp_in_ready_low", in_ready_s, 0);
        repeat (3) @(negedge clk);
        #2;
        check("bp_held_data", out_data_s, 44);
        check("bp_held_idx", out_idx_s, 1);
        @(negedge clk);
        out_ready = 1'b1;
        send1(8'd9);
        in_valid = 1'b0;
        #2;
        check("bp_valid_stays", out_valid_s, 1);
        check("bp_data", out_data_s, 9);
        check("bp_idx", out_idx_s, 3);
        @(negedge clk);
        @(negedge clk);

        // Reset mid-window discards the partial window.
        send1(8'd10);
        send1(8'd20);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid_s, 0);
        check("midrst_in_ready", in_ready_s, 1);
        win.delete();
        exp_s.delete();
        exp_u.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send1(8'd1); send1(8'd2); send1(8'd3); send1(8'd4);
        in_valid = 1'b0;
        #2;
        check("midrst_data", out_data_s, 4);
        check("midrst_idx", out_idx_s, 3);
        @(negedge clk);
        @(negedge clk);

        // Continuous random stream: no bubbles, 16 results.
        base    = results_s;
        bubbles = 0;
        for (int i = 0; i < 64; i++) begin
            send(W'($urandom_range(0, 255)), stalls);
            bubbles += stalls;
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("stream_bubbles", bubbles, 0);
        check("stream_results", results_s - base, 16);

        check("end_queue_s", exp_s.size(), 0);
        check("end_queue_u", exp_u.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
